// File: rtl/fetch_ctrl.sv
// fetch_ctrl -- fetch-stage redirect, stall and flush sequencer.
//
// Turns branch, trap, halt and hazard requests into the fetch-stage control
// strobes, holds the IF/ID flush for a fixed number of cycles after every
// redirect and counts issued redirects.
//
// Ports:
//   clk           in   single clock, rising edge
//   reset         in   asynchronous, active-high reset
//   hazard_stall  in   decode hazard, hold the fetch PC
//   br_req        in   taken branch/jump resolved in execute
//   br_target     in   [31:0] branch destination
//   trap_req      in   exception/interrupt redirect
//   trap_vec      in   [31:0] trap handler address
//   halt_req      in   debug halt request
//   resume_req    in   debug resume request
//   stall         out  fetch-stage stall
//   jmp           out  fetch-stage jump strobe
//   jmp_pc        out  [31:0] fetch-stage jump address (0 when jmp=0)
//   flush_ifid    out  invalidate IF/ID register
//   halted        out  high while halted
//   redirect_cnt  out  [15:0] saturating count of issued redirects
module fetch_ctrl #(
    parameter logic [31:0] BOOT_PC      = 32'h0000_0000,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hazard_stall,
    input  logic        br_req,
    input  logic [31:0] br_target,
    input  logic        trap_req,
    input  logic [31:0] trap_vec,
    input  logic        halt_req,
    input  logic        resume_req,
    output logic        stall,
    output logic        jmp,
    output logic [31:0] jmp_pc,
    output logic        flush_ifid,
    output logic        halted,
    output logic [15:0] redirect_cnt
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(FLUSH_CYCLES - 1);

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;

    // Redirect targets are halfword aligned: bit 0 is always dropped.
    logic [31:0] trap_pc, br_pc;
    assign trap_pc = {trap_vec[31:1], 1'b0};
    assign br_pc   = {br_target[31:1], 1'b0};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= BOOT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        stall      = 1'b0;
        jmp        = 1'b0;
        jmp_pc     = '0;
        flush_ifid = 1'b0;
        case (state)
            BOOT: begin
                jmp        = 1'b1;
                jmp_pc     = BOOT_PC;
                flush_ifid = 1'b1;
                state_nxt  = FLUSH;
                cnt_nxt    = CNT_LOAD;
            end
            RUN: begin
                if (trap_req) begin
                    jmp       = 1'b1;
                    jmp_pc    = trap_pc;
                    state_nxt = FLUSH;
                    cnt_nxt   = CNT_LOAD;
                end else if (br_req) begin
                    jmp       = 1'b1;
                    jmp_pc    = br_pc;
                    state_nxt = FLUSH;
                    cnt_nxt   = CNT_LOAD;
                end else if (halt_req) begin
                    stall     = 1'b1;
                    state_nxt = HALT;
                end else if (hazard_stall) begin
                    stall = 1'b1;
                end
            end
            FLUSH: begin
                flush_ifid = 1'b1;
                // A trap restarts the flush window from the top.
                if (trap_req) begin
                    jmp     = 1'b1;
                    jmp_pc  = trap_pc;
                    cnt_nxt = CNT_LOAD;
                end else if (cnt == 4'd0) begin
                    state_nxt = RUN;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            HALT: begin
                stall = 1'b1;
                if (trap_req) begin
                    jmp       = 1'b1;
                    jmp_pc    = trap_pc;
                    state_nxt = FLUSH;
                    cnt_nxt   = CNT_LOAD;
                end else if (resume_req) begin
                    state_nxt = RUN;
                end
            end
            default: state_nxt = BOOT;
        endcase
    end

    assign halted = (state == HALT);

    // The BOOT jump is not a redirect and is not counted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            redirect_cnt <= '0;
        end else if (jmp && (state != BOOT) && (redirect_cnt != '1)) begin
            redirect_cnt <= redirect_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl -- directed, table-driven bench for fetch_ctrl.
// Instance dut uses the default parameters; dut4 uses FLUSH_CYCLES=4 and a
// non-zero BOOT_PC and shares all inputs with dut.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        hazard_stall, br_req, trap_req, halt_req, resume_req;
    logic [31:0] br_target, trap_vec;

    logic        stall, jmp, flush_ifid, halted;
    logic [31:0] jmp_pc;
    logic [15:0] redirect_cnt;

    logic        d4_stall, d4_jmp, d4_flush, d4_halted;
    logic [31:0] d4_pc;
    logic [15:0] d4_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    logic [15:0] exp_cnt;

    always #5 clk = ~clk;

    fetch_ctrl dut (
        .clk(clk), .reset(reset), .hazard_stall(hazard_stall),
        .br_req(br_req), .br_target(br_target), .trap_req(trap_req),
        .trap_vec(trap_vec), .halt_req(halt_req), .resume_req(resume_req),
        .stall(stall), .jmp(jmp), .jmp_pc(jmp_pc), .flush_ifid(flush_ifid),
        .halted(halted), .redirect_cnt(redirect_cnt)
    );

    fetch_ctrl #(.BOOT_PC(32'h0000_1000), .FLUSH_CYCLES(4)) dut4 (
        .clk(clk), .reset(reset), .hazard_stall(hazard_stall),
        .br_req(br_req), .br_target(br_target), .trap_req(trap_req),
        .trap_vec(trap_vec), .halt_req(halt_req), .resume_req(resume_req),
        .stall(d4_stall), .jmp(d4_jmp), .jmp_pc(d4_pc), .flush_ifid(d4_flush),
        .halted(d4_halted), .redirect_cnt(d4_cnt)
    );

    typedef struct {
        logic        trap, br, halt, hz;
        logic [31:0] tgt, vec;
        logic        e_stall, e_jmp;
        logic [31:0] e_pc;
        logic        e_flush, e_halted;
    } vec_t;

    vec_t vt[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        hazard_stall = 0; br_req = 0; trap_req = 0; halt_req = 0; resume_req = 0;
        br_target = '0; trap_vec = '0;
    endtask

    // Wait (bounded) until dut is back in RUN.
    task automatic wait_run(input string name);
        int n = 0;
        while ((flush_ifid || halted) && n < 20) begin
            @(negedge clk);
            n++;
        end
        n_tests++;
        if (n >= 20) begin
            n_fail++;
            $display("FAIL %s: timeout waiting for RUN, got flush=%b halted=%b expected 0/0",
                     name, flush_ifid, halted);
        end
    endtask

    // Called right after reset is released at a negedge.
    task automatic boot_seq(input string tag);
        #1;
        check({tag, "_boot_jmp"}, 32'(jmp), 32'd1);
        check({tag, "_boot_pc"}, jmp_pc, 32'h0);
        check({tag, "_boot_flush"}, 32'(flush_ifid), 32'd1);
        check({tag, "_boot_stall"}, 32'(stall), 32'd0);
        @(negedge clk);
        check({tag, "_f1_jmp"}, 32'(jmp), 32'd0);
        check({tag, "_f1_pc"}, jmp_pc, 32'h0);
        check({tag, "_f1_flush"}, 32'(flush_ifid), 32'd1);
        @(negedge clk);
        check({tag, "_f2_flush"}, 32'(flush_ifid), 32'd1);
        @(negedge clk);
        check({tag, "_run_flush"}, 32'(flush_ifid), 32'd0);
        check({tag, "_run_jmp"}, 32'(jmp), 32'd0);
        check({tag, "_run_stall"}, 32'(stall), 32'd0);
        check({tag, "_run_cnt"}, 32'(redirect_cnt), 32'd0);
        exp_cnt = '0;
    endtask

    initial begin
        int n;
        clear_inputs();
        reset = 1'b1;

        vt[0] = '{0,0,0,0, 32'h0,         32'h0,         0,0, 32'h0,         0,0};
        vt[1] = '{0,0,0,1, 32'h0,         32'h0,         1,0, 32'h0,         0,0};
        vt[2] = '{0,1,0,0, 32'h0000_0123, 32'h0,         0,1, 32'h0000_0122, 1,0};
        vt[3] = '{1,1,0,0, 32'h0000_0200, 32'h0000_0100, 0,1, 32'h0000_0100, 1,0};
        vt[4] = '{0,0,1,1, 32'h0,         32'h0,         1,0, 32'h0,         0,1};
        vt[5] = '{1,0,0,0, 32'h0,         32'h8000_0001, 0,1, 32'h8000_0000, 1,0};
        vt[6] = '{0,1,0,1, 32'hFFFF_FFFF, 32'h0,         0,1, 32'hFFFF_FFFE, 1,0};
        vt[7] = '{0,1,1,0, 32'h0000_0345, 32'h0,         0,1, 32'h0000_0344, 1,0};
        vt[8] = '{1,0,1,1, 32'h0,         32'h0000_0abc, 0,1, 32'h0000_0abc, 1,0};

        // Reset values, before any clock edge.
        #3;
        check("rst_jmp", 32'(jmp), 32'd1);
        check("rst_pc", jmp_pc, 32'h0);
        check("rst_flush", 32'(flush_ifid), 32'd1);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_cnt", 32'(redirect_cnt), 32'd0);
        check("rst_d4_pc", d4_pc, 32'h0000_1000);
        @(posedge clk);
        #1 check("rst_hold_jmp", 32'(jmp), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        boot_seq("init");

        // Single-cycle request vectors applied from RUN.
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            trap_req = vt[i].trap; br_req = vt[i].br; halt_req = vt[i].halt;
            hazard_stall = vt[i].hz; br_target = vt[i].tgt; trap_vec = vt[i].vec;
            #1;
            check($sformatf("v%0d_stall", i), 32'(stall), 32'(vt[i].e_stall));
            check($sformatf("v%0d_jmp", i), 32'(jmp), 32'(vt[i].e_jmp));
            check($sformatf("v%0d_pc", i), jmp_pc, vt[i].e_pc);
            if (vt[i].e_jmp) exp_cnt = exp_cnt + 16'd1;
            @(posedge clk);
            #1 clear_inputs();
            @(negedge clk);
            check($sformatf("v%0d_flush", i), 32'(flush_ifid), 32'(vt[i].e_flush));
            check($sformatf("v%0d_halted", i), 32'(halted), 32'(vt[i].e_halted));
            check($sformatf("v%0d_stall_after", i), 32'(stall), 32'(vt[i].e_halted));
            check($sformatf("v%0d_cnt", i), 32'(redirect_cnt), 32'(exp_cnt));
            if (halted) begin
                resume_req = 1'b1;
                @(posedge clk);
                #1 resume_req = 1'b0;
                @(negedge clk);
            end
            wait_run($sformatf("v%0d_recover", i));
        end

        // Branch: exactly two flush cycles, then RUN.
        @(negedge clk);
        br_req = 1; br_target = 32'h0000_0123;
        #1 check("br_pc", jmp_pc, 32'h0000_0122);
        exp_cnt = exp_cnt + 16'd1;
        @(posedge clk);
        #1 clear_inputs();
        n = 0;
        @(negedge clk);
        while (flush_ifid && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("br_flush_len", n, 2);
        check("br_cnt", 32'(redirect_cnt), 32'(exp_cnt));

        // Trap beats branch; requests during FLUSH are ignored.
        @(negedge clk);
        trap_req = 1; br_req = 1; trap_vec = 32'h100; br_target = 32'h200;
        #1 check("tb_pc", jmp_pc, 32'h100);
        exp_cnt = exp_cnt + 16'd1;
        @(posedge clk);
        #1 clear_inputs();
        br_req = 1; br_target = 32'h200; halt_req = 1; hazard_stall = 1;
        @(negedge clk);
        check("fl_ign_jmp", 32'(jmp), 32'd0);
        check("fl_ign_pc", jmp_pc, 32'h0);
        check("fl_ign_stall", 32'(stall), 32'd0);
        check("fl_ign_flush", 32'(flush_ifid), 32'd1);
        @(posedge clk);
        #1 clear_inputs();
        @(negedge clk);
        check("fl_ign_flush2", 32'(flush_ifid), 32'd1);
        @(negedge clk);
        check("fl_ign_run_flush", 32'(flush_ifid), 32'd0);
        check("fl_ign_run_halted", 32'(halted), 32'd0);
        check("fl_ign_cnt", 32'(redirect_cnt), 32'(exp_cnt));

        // HALT: branch/hazard ignored, resume, then trap out of HALT.
        @(negedge clk);
        halt_req = 1; hazard_stall = 1;
        #1 check("h_stall", 32'(stall), 32'd1);
        @(posedge clk);
        #1 clear_inputs();
        br_req = 1; br_target = 32'h300; hazard_stall = 1;
        @(negedge clk);
        check("h_halted", 32'(halted), 32'd1);
        check("h_stall2", 32'(stall), 32'd1);
        check("h_br_jmp", 32'(jmp), 32'd0);
        check("h_br_pc", jmp_pc, 32'h0);
        @(posedge clk);
        #1 clear_inputs();
        resume_req = 1;
        @(negedge clk);
        check("h_still_halted", 32'(halted), 32'd1);
        @(posedge clk);
        #1 clear_inputs();
        @(negedge clk);
        check("h_res_halted", 32'(halted), 32'd0);
        check("h_res_stall", 32'(stall), 32'd0);
        check("h_res_flush", 32'(flush_ifid), 32'd0);
        halt_req = 1;
        @(posedge clk);
        #1 clear_inputs();
        trap_req = 1; trap_vec = 32'h401;
        @(negedge clk);
        check("ht_jmp", 32'(jmp), 32'd1);
        check("ht_pc", jmp_pc, 32'h400);
        exp_cnt = exp_cnt + 16'd1;
        @(posedge clk);
        #1 clear_inputs();
        @(negedge clk);
        check("ht_halted", 32'(halted), 32'd0);
        check("ht_flush", 32'(flush_ifid), 32'd1);
        check("ht_cnt", 32'(redirect_cnt), 32'(exp_cnt));
        wait_run("ht_recover");

        // Asynchronous reset mid-FLUSH.
        @(negedge clk);
        br_req = 1; br_target = 32'h50;
        @(posedge clk);
        #1 clear_inputs();
        #2 reset = 1'b1;
        #1;
        check("arf_jmp", 32'(jmp), 32'd1);
        check("arf_pc", jmp_pc, 32'h0);
        check("arf_cnt", 32'(redirect_cnt), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        boot_seq("arf");

        // Asynchronous reset mid-HALT.
        @(negedge clk);
        halt_req = 1;
        @(posedge clk);
        #1 clear_inputs();
        #2 reset = 1'b1;
        #1;
        check("arh_halted", 32'(halted), 32'd0);
        check("arh_stall", 32'(stall), 32'd0);
        check("arh_jmp", 32'(jmp), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        boot_seq("arh");

        // FLUSH_CYCLES=4: trap in the cycle after the branch redirect restarts
        // the window, giving 5 flush cycles in total.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1 check("d4_boot_pc", d4_pc, 32'h0000_1000);
        repeat (8) @(negedge clk);
        check("d4_run_flush", 32'(d4_flush), 32'd0);
        br_req = 1; br_target = 32'h601;
        #1;
        check("d4_br_jmp", 32'(d4_jmp), 32'd1);
        check("d4_br_pc", d4_pc, 32'h600);
        @(posedge clk);
        #1 clear_inputs();
        @(negedge clk);
        check("d4_f1_flush", 32'(d4_flush), 32'd1);
        trap_req = 1; trap_vec = 32'h700;
        #1;
        check("d4_tr_jmp", 32'(d4_jmp), 32'd1);
        check("d4_tr_pc", d4_pc, 32'h700);
        @(posedge clk);
        #1 clear_inputs();
        n = 1;
        @(negedge clk);
        while (d4_flush && n < 30) begin
            n++;
            @(negedge clk);
        end
        check("d4_flush_total", n, 5);
        check("d4_cnt", 32'(d4_cnt), 32'd2);

        // Counter saturation: a held trap redirects every cycle.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        boot_seq("sat");
        @(negedge clk);
        trap_req = 1; trap_vec = 32'h800;
        repeat (65534) @(posedge clk);
        #1 clear_inputs();
        @(negedge clk);
        check("sat_fffe", 32'(redirect_cnt), 32'h0000_FFFE);
        wait_run("sat_recover");
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            br_req = 1; br_target = 32'h900;
            #1 check($sformatf("sat_b%0d_jmp", k), 32'(jmp), 32'd1);
            @(posedge clk);
            #1 clear_inputs();
            @(negedge clk);
            check($sformatf("sat_b%0d_cnt", k), 32'(redirect_cnt), 32'h0000_FFFF);
            wait_run($sformatf("sat_b%0d_recover", k));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
